write_resp_slave_mngr: RTL and testbench

- Target-side (responder) counterpart of the initiator write path: accepts write requests (aw*), write data beats (w*) and returns write responses (b*) on the same 32-bit beat / 128-bit line protocol.
- Assembles four 32-bit beats into one 128-bit masked line write toward a memory/peripheral port.
- Sits between the bus interconnect and a line-wide memory controller.

---
 rtl/write_resp_slave_mngr_pkg.sv | 41 ++++
 rtl/write_resp_slave_mngr_fifo.sv | 59 +++++
 rtl/write_resp_slave_mngr.sv | 194 +++++++++++++++++++
 tb/tb_write_resp_slave_mngr.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/write_resp_slave_mngr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : write_resp_slave_mngr_pkg
// Description : Shared widths, entry layouts and W-stage state encoding for
//               the write-response target manager.
// Revision    : 1.0 - initial release
// ============================================================================
package write_resp_slave_mngr_pkg;

    localparam int c_id_w    = 4;
    localparam int c_beats   = 4;
    localparam int c_beat_w  = 32;
    localparam int c_strb_w  = 4;
    localparam int c_line_w  = 128;
    localparam int c_mask_w  = 16;

    localparam logic [5:0] c_atop_none = 6'd0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_MEMWR   = 2'd2
    } wstate_e;

    typedef struct packed {
        logic [c_id_w-1:0] id;
        logic [31:0]       addr;
        logic              atop_err;
    } aw_entry_t;

    typedef struct packed {
        logic [c_id_w-1:0] id;
        logic              comp;
    } b_entry_t;

    function automatic logic [31:0] line_addr(input logic [31:0] byte_addr);
        return {byte_addr[31:4], 4'b0000};
    endfunction

endpackage
`default_nettype wire

// File: rtl/write_resp_slave_mngr_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Synchronous FIFO with wrap-bit pointers; push when full and
//               pop when empty are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int                 c_pw    = $clog2(DEPTH);
    localparam logic [c_pw:0]      c_depth = (c_pw+1)'(DEPTH);

    logic [c_pw:0]      r_wr_ptr;
    logic [c_pw:0]      r_rd_ptr;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic               w_push;
    logic               w_pop;

    assign count    = r_wr_ptr - r_rd_ptr;
    assign full     = (count == c_depth);
    assign empty    = (r_wr_ptr == r_rd_ptr);
    assign w_push   = push && !full;
    assign w_pop    = pop && !empty;
    assign pop_data = r_mem[r_rd_ptr[c_pw-1:0]];

    // Storage is cleared too so the head reads as zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr[c_pw-1:0]] <= push_data;
                r_wr_ptr                  <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/write_resp_slave_mngr.sv
`default_nettype none
// ============================================================================
// Module      : write_resp_slave_mngr
// Description : Target-side write manager: queues requests, assembles four
//               32-bit beats into a masked 128-bit line write, returns responses.
// Revision    : 1.0 - initial release
// ============================================================================
module write_resp_slave_mngr #(
    parameter int AW_DEPTH = 2,
    parameter int B_DEPTH  = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          awvalid,
    output logic          awready,
    input  logic [3:0]    awid,
    input  logic [31:0]   awaddr,
    input  logic [5:0]    awatop,
    input  logic          wvalid,
    output logic          wready,
    input  logic [31:0]   wdata,
    input  logic [3:0]    wstrb,
    input  logic          wlast,
    output logic          bvalid,
    input  logic          bready,
    output logic [3:0]    bid,
    output logic          bcomp,
    output logic          mem_wvalid,
    input  logic          mem_wready,
    output logic [31:0]   mem_addr,
    output logic [127:0]  mem_wdata,
    output logic [15:0]   mem_mask
);

    import write_resp_slave_mngr_pkg::*;

    localparam int             c_awp      = $clog2(AW_DEPTH);
    localparam int             c_bp       = $clog2(B_DEPTH);
    localparam logic [c_awp:0] c_aw_depth = (c_awp+1)'(AW_DEPTH);
    localparam logic [c_bp:0]  c_b_depth  = (c_bp+1)'(B_DEPTH);

    wstate_e              r_state;
    logic                 r_awready;
    logic                 r_wready;
    logic [1:0]           r_beat;
    logic [c_id_w-1:0]    r_id;
    logic                 r_ok;

    aw_entry_t            w_aw_in;
    aw_entry_t            w_aw_head;
    logic                 w_aw_full;
    logic                 w_aw_empty;
    logic [c_awp:0]       w_aw_count;
    logic [c_awp:0]       w_aw_cnt_next;
    logic                 w_aw_push;
    logic                 w_aw_pop;
    logic                 w_aw_avail;

    b_entry_t             w_b_in;
    b_entry_t             w_b_head;
    logic                 w_b_full;
    logic                 w_b_empty;
    logic [c_bp:0]        w_b_count;
    logic                 w_b_push;
    logic                 w_b_pop;
    logic                 w_b_credit;

    logic                 w_beat_acc;
    logic                 w_last_beat;
    logic                 w_line_end;
    logic                 w_line_err;

    assign awready = r_awready;
    assign wready  = r_wready;
    assign bvalid  = !w_b_empty;
    assign bid     = w_b_head.id;
    assign bcomp   = w_b_head.comp;

    assign w_aw_in       = '{id: awid, addr: awaddr, atop_err: (awatop != c_atop_none)};
    assign w_aw_push     = awvalid && r_awready && !w_aw_full;
    assign w_aw_cnt_next = w_aw_count + (c_awp+1)'(w_aw_push) - (c_awp+1)'(w_aw_pop);
    // A push this cycle is already at the head next cycle, so IDLE may commit now.
    assign w_aw_avail    = !w_aw_empty || w_aw_push;

    assign w_beat_acc  = (r_state == ST_COLLECT) && r_wready && wvalid;
    assign w_last_beat = (r_beat == 2'd3);
    assign w_line_end  = wlast || w_last_beat;
    assign w_line_err  = (wlast != w_last_beat);
    assign w_aw_pop    = w_beat_acc && w_line_end;

    // Only one line is ever in flight, and it holds no credit while in IDLE.
    assign w_b_credit = (w_b_count < c_b_depth);
    assign w_b_pop    = bvalid && bready;
    assign w_b_push   = !w_b_full &&
                        ((w_aw_pop && w_aw_head.atop_err) ||
                         ((r_state == ST_MEMWR) && mem_wready));
    assign w_b_in     = (r_state == ST_MEMWR) ? '{id: r_id, comp: r_ok}
                                              : '{id: w_aw_head.id, comp: 1'b0};

    sync_fifo #(
        .WIDTH ($bits(aw_entry_t)),
        .DEPTH (AW_DEPTH)
    ) u_aw_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_aw_push),
        .push_data (w_aw_in),
        .pop       (w_aw_pop),
        .pop_data  (w_aw_head),
        .full      (w_aw_full),
        .empty     (w_aw_empty),
        .count     (w_aw_count)
    );

    sync_fifo #(
        .WIDTH ($bits(b_entry_t)),
        .DEPTH (B_DEPTH)
    ) u_b_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_b_push),
        .push_data (w_b_in),
        .pop       (w_b_pop),
        .pop_data  (w_b_head),
        .full      (w_b_full),
        .empty     (w_b_empty),
        .count     (w_b_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_awready <= 1'b0;
        end else begin
            r_awready <= (w_aw_cnt_next != c_aw_depth);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_wready   <= 1'b0;
            r_beat     <= 2'd0;
            r_id       <= '0;
            r_ok       <= 1'b0;
            mem_wvalid <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_mask   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_aw_avail && w_b_credit) begin
                        r_state   <= ST_COLLECT;
                        r_wready  <= 1'b1;
                        r_beat    <= 2'd0;
                        mem_wdata <= '0;
                        mem_mask  <= '0;
                    end
                end
                ST_COLLECT: begin
                    if (w_beat_acc) begin
                        mem_wdata[{r_beat, 5'd0} +: c_beat_w] <= wdata;
                        mem_mask[{r_beat, 2'd0} +: c_strb_w]  <= wstrb;
                        r_beat <= r_beat + 2'd1;
                        if (w_line_end) begin
                            r_wready <= 1'b0;
                            r_id     <= w_aw_head.id;
                            r_ok     <= !w_line_err;
                            if (w_aw_head.atop_err) begin
                                r_state <= ST_IDLE;
                            end else begin
                                mem_addr   <= line_addr(w_aw_head.addr);
                                mem_wvalid <= 1'b1;
                                r_state    <= ST_MEMWR;
                            end
                        end
                    end
                end
                ST_MEMWR: begin
                    if (mem_wready) begin
                        mem_wvalid <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_wready <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_write_resp_slave_mngr.sv
`default_nettype none
// ============================================================================
// Module      : tb_write_resp_slave_mngr
// Description : Directed self-checking bench for write_resp_slave_mngr.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_write_resp_slave_mngr;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          awvalid = 1'b0;
    logic          awready;
    logic [3:0]    awid = '0;
    logic [31:0]   awaddr = '0;
    logic [5:0]    awatop = '0;
    logic          wvalid = 1'b0;
    logic          wready;
    logic [31:0]   wdata = '0;
    logic [3:0]    wstrb = '0;
    logic          wlast = 1'b0;
    logic          bvalid;
    logic          bready = 1'b0;
    logic [3:0]    bid;
    logic          bcomp;
    logic          mem_wvalid;
    logic          mem_wready = 1'b0;
    logic [31:0]   mem_addr;
    logic [127:0]  mem_wdata;
    logic [15:0]   mem_mask;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    write_resp_slave_mngr #(.AW_DEPTH(2), .B_DEPTH(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .awvalid    (awvalid),
        .awready    (awready),
        .awid       (awid),
        .awaddr     (awaddr),
        .awatop     (awatop),
        .wvalid     (wvalid),
        .wready     (wready),
        .wdata      (wdata),
        .wstrb      (wstrb),
        .wlast      (wlast),
        .bvalid     (bvalid),
        .bready     (bready),
        .bid        (bid),
        .bcomp      (bcomp),
        .mem_wvalid (mem_wvalid),
        .mem_wready (mem_wready),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_mask   (mem_mask)
    );

    // Stimulus helpers: called at a negedge, return at the negedge after the handshake.
    task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [5:0] atop);
        int n = 0;
        awvalid = 1'b1; awid = id; awaddr = addr; awatop = atop;
        while (!awready && n < 200) begin @(negedge clk); n++; end
        if (!awready) begin
            checks++; errors++;
            $display("FAIL aw_timeout: awready=%b required 1", awready);
        end
        @(negedge clk);
        awvalid = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] s, input logic l);
        int n = 0;
        wvalid = 1'b1; wdata = d; wstrb = s; wlast = l;
        while (!wready && n < 200) begin @(negedge clk); n++; end
        if (!wready) begin
            checks++; errors++;
            $display("FAIL w_timeout: wready=%b required 1", wready);
        end
        @(negedge clk);
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic mem_accept();
        int n = 0;
        while (!mem_wvalid && n < 200) begin @(negedge clk); n++; end
        if (!mem_wvalid) begin
            checks++; errors++;
            $display("FAIL mem_timeout: mem_wvalid=%b required 1", mem_wvalid);
        end
        mem_wready = 1'b1;
        @(negedge clk);
        mem_wready = 1'b0;
    endtask

    task automatic pop_b();
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({awready, wready, bvalid, bid, bcomp, mem_wvalid} !== 9'b0 ||
            mem_addr !== 32'h0 || mem_wdata !== 128'h0 || mem_mask !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs: aw=%b w=%b b=%b bid=%h bc=%b mv=%b ma=%h md=%h mm=%h required all 0",
                     awready, wready, bvalid, bid, bcomp, mem_wvalid, mem_addr, mem_wdata, mem_mask);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (awready !== 1'b1) begin
            errors++; $display("FAIL reset_release_awready: got %b required 1", awready);
        end
    endtask

    task automatic test_single_write();
        send_aw(4'd3, 32'h0000_0100, 6'd0);
        checks++;
        if (wready !== 1'b1) begin
            errors++; $display("FAIL single_wready_latency: got %b required 1", wready);
        end
        send_beat(32'h1111_1111, 4'hF, 1'b0);
        send_beat(32'h2222_2222, 4'hF, 1'b0);
        send_beat(32'h3333_3333, 4'hF, 1'b0);
        send_beat(32'h4444_4444, 4'hF, 1'b1);
        checks++;
        if (mem_wvalid !== 1'b1 || wready !== 1'b0 || mem_addr !== 32'h0000_0100 ||
            mem_wdata !== 128'h44444444_33333333_22222222_11111111 || mem_mask !== 16'hFFFF) begin
            errors++;
            $display("FAIL single_line: mv=%b wr=%b addr=%h data=%h mask=%h required 1 0 00000100 44444444333333332222222211111111 ffff",
                     mem_wvalid, wready, mem_addr, mem_wdata, mem_mask);
        end
        mem_accept();
        checks++;
        if (mem_wvalid !== 1'b0 || bvalid !== 1'b1 || bid !== 4'd3 || bcomp !== 1'b1) begin
            errors++;
            $display("FAIL single_resp: mv=%b bvalid=%b bid=%h bcomp=%b required 0 1 3 1", mem_wvalid, bvalid, bid, bcomp);
        end
        pop_b();
        checks++;
        if (bvalid !== 1'b0) begin
            errors++; $display("FAIL single_pop: bvalid=%b required 0", bvalid);
        end
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        send_aw(4'd1, 32'h0000_0200, 6'd0);
        send_aw(4'd2, 32'h0000_0300, 6'd0);
        send_beat(32'hA000_0000, 4'hF, 1'b0);
        send_beat(32'hA000_0001, 4'hF, 1'b0);
        send_beat(32'hA000_0002, 4'hF, 1'b0);
        send_beat(32'hA000_0003, 4'hF, 1'b1);
        wvalid = 1'b1; wdata = 32'hB000_0000; wstrb = 4'hF;
        for (int i = 0; i < 5; i++) begin
            if (wready !== 1'b0 || mem_wvalid !== 1'b1 || mem_addr !== 32'h0000_0200 ||
                mem_wdata !== 128'hA0000003_A0000002_A0000001_A0000000) bad++;
            @(negedge clk);
        end
        wvalid = 1'b0;
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL b2b_stall: %0d bad cycles required 0", bad);
        end
        mem_accept();
        send_beat(32'hB000_0000, 4'hF, 1'b0);
        send_beat(32'hB000_0001, 4'hF, 1'b0);
        send_beat(32'hB000_0002, 4'hF, 1'b0);
        send_beat(32'hB000_0003, 4'hF, 1'b1);
        checks++;
        if (mem_addr !== 32'h0000_0300 || mem_wdata !== 128'hB0000003_B0000002_B0000001_B0000000) begin
            errors++; $display("FAIL b2b_line2: addr=%h data=%h required 00000300 b0000003b0000002b0000001b0000000", mem_addr, mem_wdata);
        end
        mem_accept();
        checks++;
        if (bvalid !== 1'b1 || bid !== 4'd1 || bcomp !== 1'b1) begin
            errors++; $display("FAIL b2b_resp1: bvalid=%b bid=%h bcomp=%b required 1 1 1", bvalid, bid, bcomp);
        end
        pop_b();
        checks++;
        if (bvalid !== 1'b1 || bid !== 4'd2 || bcomp !== 1'b1) begin
            errors++; $display("FAIL b2b_resp2: bvalid=%b bid=%h bcomp=%b required 1 2 1", bvalid, bid, bcomp);
        end
        pop_b();
    endtask

    task automatic test_short_line();
        send_aw(4'd5, 32'h0000_0404, 6'd0);
        send_beat(32'hAAAA_AAAA, 4'hF, 1'b0);
        send_beat(32'hBBBB_BBBB, 4'h3, 1'b1);
        checks++;
        if (mem_wvalid !== 1'b1 || mem_addr !== 32'h0000_0400 || mem_mask !== 16'h003F ||
            mem_wdata !== 128'h00000000_00000000_BBBBBBBB_AAAAAAAA) begin
            errors++;
            $display("FAIL short_line: mv=%b addr=%h mask=%h data=%h required 1 00000400 003f 0000000000000000bbbbbbbbaaaaaaaa",
                     mem_wvalid, mem_addr, mem_mask, mem_wdata);
        end
        mem_accept();
        checks++;
        if (bvalid !== 1'b1 || bid !== 4'd5 || bcomp !== 1'b0) begin
            errors++; $display("FAIL short_resp: bvalid=%b bid=%h bcomp=%b required 1 5 0", bvalid, bid, bcomp);
        end
        pop_b();
    endtask

    task automatic test_atomic();
        send_aw(4'd7, 32'h0000_0500, 6'h20);
        send_beat(32'hC000_0000, 4'hF, 1'b0);
        send_beat(32'hC000_0001, 4'hF, 1'b0);
        send_beat(32'hC000_0002, 4'hF, 1'b0);
        send_beat(32'hC000_0003, 4'hF, 1'b1);
        checks++;
        if (mem_wvalid !== 1'b0 || bvalid !== 1'b1 || bid !== 4'd7 || bcomp !== 1'b0) begin
            errors++;
            $display("FAIL atomic_resp: mv=%b bvalid=%b bid=%h bcomp=%b required 0 1 7 0", mem_wvalid, bvalid, bid, bcomp);
        end
        pop_b();
    endtask

    task automatic test_b_backpressure();
        int bad = 0;
        for (int i = 0; i < 2; i++) begin
            send_aw(4'(8 + i), 32'h0000_0800 + 32'(i * 16), 6'd0);
            send_beat(32'hD000_0000, 4'hF, 1'b0);
            send_beat(32'hD000_0001, 4'hF, 1'b0);
            send_beat(32'hD000_0002, 4'hF, 1'b0);
            send_beat(32'hD000_0003, 4'hF, 1'b1);
            mem_accept();
        end
        send_aw(4'd10, 32'h0000_0820, 6'd0);
        for (int i = 0; i < 6; i++) begin
            if (wready !== 1'b0 || bvalid !== 1'b1 || bid !== 4'd8 || bcomp !== 1'b1) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL bp_hold: %0d bad cycles required 0 (wready 0, bid 8 bcomp 1)", bad);
        end
        pop_b();
        checks++;
        if (bvalid !== 1'b1 || bid !== 4'd9 || bcomp !== 1'b1) begin
            errors++; $display("FAIL bp_after_pop: bvalid=%b bid=%h bcomp=%b required 1 9 1", bvalid, bid, bcomp);
        end
        send_beat(32'hE000_0000, 4'hF, 1'b0);
        send_beat(32'hE000_0001, 4'hF, 1'b0);
        send_beat(32'hE000_0002, 4'hF, 1'b0);
        send_beat(32'hE000_0003, 4'hF, 1'b1);
        checks++;
        if (mem_addr !== 32'h0000_0820 || mem_wdata !== 128'hE0000003_E0000002_E0000001_E0000000) begin
            errors++; $display("FAIL bp_line3: addr=%h data=%h required 00000820 e0000003e0000002e0000001e0000000", mem_addr, mem_wdata);
        end
        mem_accept();
        pop_b();
        checks++;
        if (bvalid !== 1'b1 || bid !== 4'd10 || bcomp !== 1'b1) begin
            errors++; $display("FAIL bp_resp3: bvalid=%b bid=%h bcomp=%b required 1 a 1", bvalid, bid, bcomp);
        end
        pop_b();
    endtask

    task automatic test_reset_mid_line();
        send_aw(4'd11, 32'h0000_0600, 6'd0);
        send_beat(32'hF000_0000, 4'hF, 1'b0);
        send_beat(32'hF000_0001, 4'hF, 1'b0);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({awready, wready, bvalid, bid, bcomp, mem_wvalid} !== 9'b0 ||
            mem_addr !== 32'h0 || mem_wdata !== 128'h0 || mem_mask !== 16'h0) begin
            errors++;
            $display("FAIL midreset_outputs: aw=%b w=%b b=%b bid=%h bc=%b mv=%b ma=%h md=%h mm=%h required all 0",
                     awready, wready, bvalid, bid, bcomp, mem_wvalid, mem_addr, mem_wdata, mem_mask);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_aw(4'd12, 32'h0000_0700, 6'd0);
        send_beat(32'h0102_0304, 4'hF, 1'b0);
        send_beat(32'h0506_0708, 4'hF, 1'b0);
        send_beat(32'h090A_0B0C, 4'hF, 1'b0);
        send_beat(32'h0D0E_0F10, 4'hC, 1'b1);
        checks++;
        if (mem_addr !== 32'h0000_0700 || mem_mask !== 16'hCFFF ||
            mem_wdata !== 128'h0D0E0F10_090A0B0C_05060708_01020304) begin
            errors++;
            $display("FAIL midreset_line: addr=%h mask=%h data=%h required 00000700 cfff 0d0e0f10090a0b0c0506070801020304",
                     mem_addr, mem_mask, mem_wdata);
        end
        mem_accept();
        checks++;
        if (bvalid !== 1'b1 || bid !== 4'd12 || bcomp !== 1'b1) begin
            errors++; $display("FAIL midreset_resp: bvalid=%b bid=%h bcomp=%b required 1 c 1", bvalid, bid, bcomp);
        end
        pop_b();
        checks++;
        if (bvalid !== 1'b0) begin
            errors++; $display("FAIL midreset_drain: bvalid=%b required 0", bvalid);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_back_to_back();
        test_short_line();
        test_atomic();
        test_b_backpressure();
        test_reset_mid_line();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
